// File: rtl/fifod2mac_pkg.sv
// fifod2mac_pkg: shared state encoding, header constants and error bit positions
package fifod2mac_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;
  localparam logic [7:0] HDR0 = 8'h5A;
  localparam logic [7:0] HDR1 = 8'hA5;
  localparam logic [15:0] MIN_LEN = 16'd18;
  localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;
  localparam int ERR_TO = 0;
  localparam int ERR_UF = 1;
  function automatic logic [15:0] frame_len(input logic [11:0] len);
    logic [15:0] l;
    l = {4'h0, len} + 16'd4;
    return l < MIN_LEN ? MIN_LEN : l;
  endfunction
endpackage

// File: rtl/fifod2mac_if.sv
// fifod2mac_if: cs handshake, fifod read port and MAC UDP transmit signals
interface fifod2mac_if;
  logic fs;
  logic fd;
  logic [11:0] dev_tx_len;
  logic [7:0] fifod_rxd;
  logic fifod_empty;
  logic fifod_rxen;
  logic [15:0] udp_tx_len;
  logic flag_udp_tx_req;
  logic flag_udp_tx_prep;
  logic udp_txen;
  logic [7:0] udp_txd;
  logic [1:0] err;
  modport master (
    input fs, dev_tx_len, fifod_rxd, fifod_empty, flag_udp_tx_prep, udp_txen,
    output fd, fifod_rxen, udp_tx_len, flag_udp_tx_req, udp_txd, err
  );
  modport slave (
    output fs, dev_tx_len, fifod_rxd, fifod_empty, flag_udp_tx_prep, udp_txen,
    input fd, fifod_rxen, udp_tx_len, flag_udp_tx_req, udp_txd, err
  );
endinterface

// File: rtl/fifod2mac_fsm.sv
// fifod2mac_fsm: frame sequencing with fs edge detect and request timeout
module fifod2mac_fsm import fifod2mac_pkg::*; #(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   fs,
  input  logic   prep,
  input  logic   last,
  output state_t state,
  output logic   start,
  output logic   timeout
);
  localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;
  state_t nxt;
  logic fs_q;
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fs_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      fs_q <= fs;
      cnt <= state == REQ ? cnt + 16'd1 : '0;
    end
  always_comb begin
    nxt = state;
    start = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: if (fs && !fs_q) begin
        nxt = REQ;
        start = 1'b1;
      end
      REQ: if (prep) nxt = SEND;
      else if (cnt == TO_LAST) begin
        nxt = DONE;
        timeout = 1'b1;
      end
      SEND: if (last) nxt = DONE;
      DONE: if (!fs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/fifod2mac.sv
// fifod2mac: drains fifod into the MAC UDP transmit interface with a 4-byte header and zero padding
module fifod2mac import fifod2mac_pkg::*; #(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  fifod2mac_if.master bus
);
  state_t state;
  logic start, timeout, pull, last, in_pay, rd, sel_q;
  logic [11:0] len;
  logic [15:0] idx, tx_len;
  logic [7:0] byte_q, cbyte;
  logic [1:0] err;
  fifod2mac_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk(clk),
    .rst(rst),
    .fs(bus.fs),
    .prep(bus.flag_udp_tx_prep),
    .last(last),
    .state(state),
    .start(start),
    .timeout(timeout)
  );
  assign pull = bus.udp_txen && state == SEND;
  assign last = pull && idx == tx_len - 16'd1;
  assign in_pay = idx >= 16'd4 && idx < {4'h0, len} + 16'd4;
  assign rd = pull && in_pay && !bus.fifod_empty;
  assign cbyte = !pull ? 8'h00 :
                 idx == 16'd0 ? HDR0 :
                 idx == 16'd1 ? HDR1 :
                 idx == 16'd2 ? {4'h0, len[11:8]} :
                 idx == 16'd3 ? len[7:0] : 8'h00;
  // FIFO bytes are captured into byte_q once the pull ends so udp_txd holds regardless of fifod_rxd
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len <= '0;
      idx <= '0;
      tx_len <= '0;
      err <= '0;
      sel_q <= 1'b0;
      byte_q <= '0;
    end else begin
      if (start) begin
        len <= bus.dev_tx_len;
        tx_len <= frame_len(bus.dev_tx_len);
        idx <= '0;
        err <= '0;
      end else begin
        if (pull) idx <= idx + 16'd1;
        if (timeout) err[ERR_TO] <= 1'b1;
        if (pull && in_pay && bus.fifod_empty) err[ERR_UF] <= 1'b1;
      end
      if (bus.udp_txen) begin
        sel_q <= rd;
        byte_q <= cbyte;
      end else if (sel_q) begin
        sel_q <= 1'b0;
        byte_q <= bus.fifod_rxd;
      end
    end
  assign bus.fd = state == DONE;
  assign bus.flag_udp_tx_req = state == REQ;
  assign bus.fifod_rxen = rd;
  assign bus.udp_txd = sel_q ? bus.fifod_rxd : byte_q;
  assign bus.udp_tx_len = tx_len;
  assign bus.err = err;
endmodule

// File: tb/tb_fifod2mac.sv
// tb_fifod2mac: random and directed frames checked against a byte-list model of the transmit frame
module tb_fifod2mac;
  localparam logic [15:0] TO = 16'd100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int bad_rd = 0;
  logic [7:0] fq[$];
  fifod2mac_if bus();
  fifod2mac #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic txen);
    logic r;
    bus.udp_txen = txen;
    bus.fifod_empty = fq.size() == 0;
    #1;
    r = bus.fifod_rxen;
    if (r) begin
      rd_cnt++;
      if (fq.size() == 0) bad_rd++;
    end
    @(posedge clk);
    #1;
    if (r && fq.size() > 0) bus.fifod_rxd = fq.pop_front();
    #1;
  endtask
  task automatic run_frame(input int len, input int nf, input int pd, input bit gaps,
                           input int extra, input bit early, input int stop_at, input bit seq);
    logic [7:0] data[$];
    logic [7:0] exp_b[$];
    int tot, g;
    data = {};
    exp_b = {};
    fq.delete();
    rd_cnt = 0;
    bad_rd = 0;
    for (int i = 0; i < nf; i++) data.push_back(seq ? 8'(i + 1) : 8'($urandom_range(1, 255)));
    foreach (data[i]) fq.push_back(data[i]);
    exp_b.push_back(8'h5A);
    exp_b.push_back(8'hA5);
    exp_b.push_back(8'(len >> 8));
    exp_b.push_back(8'(len & 255));
    for (int i = 0; i < len; i++) exp_b.push_back(i < nf ? data[i] : 8'h00);
    while (exp_b.size() < 18) exp_b.push_back(8'h00);
    tot = exp_b.size();
    bus.dev_tx_len = 12'(len);
    bus.fs = 1'b1;
    cyc(1'b0);
    chk("req_lat", 32'(bus.flag_udp_tx_req), 1);
    repeat (pd) cyc(1'b0);
    bus.flag_udp_tx_prep = 1'b1;
    cyc(1'b0);
    bus.flag_udp_tx_prep = 1'b0;
    chk("req_drop", 32'(bus.flag_udp_tx_req), 0);
    chk("tx_len", 32'(bus.udp_tx_len), 32'(tot));
    if (early) bus.fs = 1'b0;
    for (int k = 0; k < tot; k++) begin
      if (k == stop_at) return;
      g = 0;
      while (gaps && g < 3 && $urandom_range(0, 2) == 0) begin
        g++;
        cyc(1'b0);
        if (k > 0) chk($sformatf("hold%0d", k), 32'(bus.udp_txd), 32'(exp_b[k-1]));
      end
      cyc(1'b1);
      chk($sformatf("byte%0d", k), 32'(bus.udp_txd), 32'(exp_b[k]));
    end
    chk("fd_end", 32'(bus.fd), 1);
    repeat (extra) begin
      cyc(1'b1);
      chk("post_pull", 32'(bus.udp_txd), 0);
    end
    chk("reads", 32'(rd_cnt), 32'(nf < len ? nf : len));
    chk("empty_rd", 32'(bad_rd), 0);
    chk("err", 32'(bus.err), nf < len ? 2 : 0);
    if (!early) begin
      chk("fd_hold", 32'(bus.fd), 1);
      bus.fs = 1'b0;
    end
    cyc(1'b0);
    chk("fd_drop", 32'(bus.fd), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, l, f;
    bus.fs = 1'b0;
    bus.dev_tx_len = '0;
    bus.fifod_rxd = '0;
    bus.fifod_empty = 1'b1;
    bus.flag_udp_tx_prep = 1'b0;
    bus.udp_txen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fd", 32'(bus.fd), 0);
    chk("rst_req", 32'(bus.flag_udp_tx_req), 0);
    chk("rst_rxen", 32'(bus.fifod_rxen), 0);
    chk("rst_txd", 32'(bus.udp_txd), 0);
    chk("rst_len", 32'(bus.udp_tx_len), 0);
    chk("rst_err", 32'(bus.err), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame(20, 20, 3, 0, 0, 0, -1, 1);
    run_frame(3, 3, 1, 0, 0, 0, -1, 0);
    run_frame(8, 5, 2, 0, 0, 0, -1, 0);
    fq.delete();
    rd_cnt = 0;
    bus.dev_tx_len = 12'd5;
    bus.fs = 1'b1;
    cyc(1'b0);
    n = 0;
    while (bus.flag_udp_tx_req && n < int'(TO) + 20) begin
      n++;
      cyc(1'b0);
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_err", 32'(bus.err), 1);
    chk("to_fd", 32'(bus.fd), 1);
    cyc(1'b1);
    chk("to_pull", 32'(bus.udp_txd), 0);
    chk("to_reads", 32'(rd_cnt), 0);
    bus.fs = 1'b0;
    cyc(1'b0);
    chk("to_fd_drop", 32'(bus.fd), 0);
    run_frame(20, 20, 0, 0, 0, 0, 10, 0);
    bus.udp_txen = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_fd", 32'(bus.fd), 0);
    chk("arst_req", 32'(bus.flag_udp_tx_req), 0);
    chk("arst_rxen", 32'(bus.fifod_rxen), 0);
    chk("arst_txd", 32'(bus.udp_txd), 0);
    chk("arst_len", 32'(bus.udp_tx_len), 0);
    chk("arst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.fs = 1'b0;
    bus.udp_txen = 1'b0;
    @(posedge clk);
    #1;
    run_frame(20, 20, 2, 0, 0, 0, -1, 0);
    run_frame(0, 0, 1, 1, 3, 0, -1, 0);
    run_frame(4095, 4095, 0, 0, 2, 0, -1, 0);
    for (int i = 0; i < 10; i++) begin
      l = $urandom_range(0, 40);
      f = $urandom_range(0, 3) == 0 ? $urandom_range(0, l) : l;
      run_frame(l, f, $urandom_range(0, 4), 1'b1, $urandom_range(0, 3), $urandom_range(0, 3) == 0, -1, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
